// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder slice.
package spi_pkg;

  // Responder state: waiting for select, or moving bits.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = 3;

  // Byte sent when the host has not supplied one in time.
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus a one-flop
// delayed copy of the synced level used to form rise/fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] pipe;
  logic                   dly;

  // Synchronizer chain and delayed copy, both preset to the pin's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= {SYNC_STAGES{RESET_VAL}};
      dly  <= RESET_VAL;
    end else begin
      pipe <= {pipe[SYNC_STAGES-2:0], din};
      dly  <= pipe[SYNC_STAGES-1];
    end
  end

  assign level = pipe[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first, byte-oriented SPI responder running in the local clk
// domain. Pins are oversampled; received bytes go to the host as single-cycle
// pulses, transmit bytes come from a one-entry holding register.
//
// Host transmit handshake: tx_ready is high whenever the holding register is
// empty; a byte is taken on any clk edge where tx_valid & tx_ready. tx_valid
// may be held high without a ready, and tx_data only matters on that edge.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  // Synced pins and edge strobes
  logic sclk_level_unused;  // only sclk edges matter, never its level
  logic sclk_rise;
  logic sclk_fall;
  logic ss_sync;
  logic ss_rise;
  logic ss_fall;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic mosi_sync;

  // Arming
  logic [FLUSH_W-1:0] flush_cnt;
  logic               flush_done;
  logic               armed;

  // Holding register
  logic [SPI_BYTE_W-1:0] hold_data;
  logic                  hold_full;

  // Frame engine
  spi_state_t            state;
  logic [SPI_CNT_W-1:0]  bit_cnt;
  logic                  seen_rise;
  logic [SPI_BYTE_W-2:0] rx_sr;
  logic [SPI_BYTE_W-2:0] tx_sr;  // bits still to send after the one on miso
  logic                  frame_start;
  logic                  byte_reload;
  logic                  load_now;
  logic [SPI_BYTE_W-1:0] load_byte;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ss_n),
    .level (ss_sync),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // mosi only needs the same latency as sclk so the sample lines up with the edge.
  always_ff @(posedge clk) begin
    if (rst) mosi_pipe <= '0;
    else     mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

  // Arm only after the synchronizer holds genuine pin samples and shows select
  // high; the preset value must not arm, or a frame already running at reset
  // release would be joined mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      if (!flush_done)          flush_cnt <= flush_cnt + 1'b1;
      if (flush_done && ss_sync) armed    <= 1'b1;
    end
  end

  assign flush_done = (flush_cnt == FLUSH_W'(SYNC_STAGES));

  // A byte load happens at frame start and on each falling edge that closes a full byte.
  always_comb begin
    frame_start = (state == IDLE) && ss_fall && armed;
    byte_reload = (state == SHIFT) && !ss_rise && !sclk_rise && sclk_fall &&
                  seen_rise && (bit_cnt == '0);
    load_now    = frame_start || byte_reload;
    load_byte   = hold_full ? hold_data : IDLE_BYTE;
  end

  // One-entry transmit holding register; a load empties it, a host write fills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load_now && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end
  end

  assign tx_ready = ~hold_full;

  // Frame FSM: shifts on synced sclk edges, leaves on select release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      seen_rise   <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (load_now) begin
        tx_sr       <= load_byte[SPI_BYTE_W-2:0];
        miso        <= load_byte[SPI_BYTE_W-1];
        tx_underrun <= ~hold_full;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            miso_oe   <= 1'b1;
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // Partial receive byte and unsent transmit bits are dropped.
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            rx_sr     <= {rx_sr[SPI_BYTE_W-3:0], mosi_sync};
            bit_cnt   <= bit_cnt + 1'b1;
            seen_rise <= 1'b1;
            if (bit_cnt == SPI_CNT_W'(SPI_BYTE_W - 1)) begin
              rx_data  <= {rx_sr, mosi_sync};
              rx_valid <= 1'b1;
            end
          end else if (sclk_fall && seen_rise && (bit_cnt != '0)) begin
            tx_sr <= {tx_sr[SPI_BYTE_W-3:0], 1'b0};
            miso  <= tx_sr[SPI_BYTE_W-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master, a queue model of the
// holding register and byte loads, and monitors for the host-side pulses.
module tb_spi_slave;

  localparam logic [7:0] IDLE_B = 8'h00;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  // Scoreboard state
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];   // expected miso byte for each load of a frame
  logic [7:0] hold_q[$];  // model of the holding register (0 or 1 entry)
  logic [7:0] rx_got[$];
  int         under_cnt = 0;

  // Frame plan: mosi bytes, and per load whether the host supplies a byte
  logic [7:0] fr_mo[8];
  bit         fr_prov[9];
  logic [7:0] fr_pd[9];

  // Host-side monitors
  always @(negedge clk) begin
    if (rx_valid) rx_got.push_back(rx_data);
    if (tx_underrun) under_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    check("tx_ready_pre_wr", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_post_wr", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic clock_bits(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input int half, input bit do_wr,
                           input logic [7:0] wd, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      for (int j = 0; j < half; j++) begin
        @(negedge clk);
        if (do_wr && i == 4 && j == 0) begin
          check("tx_ready_mid", {31'd0, tx_ready}, 32'd1);
          tx_data  = wd;
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
      end
      mi[i] = miso;
      sclk  = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 9; k++) begin
      fr_prov[k] = 1'b0;
      fr_pd[k]   = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < 8; k++) fr_mo[k] = 8'($urandom_range(0, 255));
  endtask

  // One full frame of nb bytes; loads = nb + 1 (frame start plus one per completed byte).
  task automatic run_frame(input int nb, input int half);
    logic [7:0] got;
    int         u0;
    int         exp_under;
    bit         wr_plan[9];
    exp_q.delete();
    exp_under = 0;
    for (int k = 0; k <= nb; k++) begin
      wr_plan[k] = fr_prov[k] && (hold_q.size() == 0);
      if (wr_plan[k]) hold_q.push_back(fr_pd[k]);
      if (hold_q.size() != 0) exp_q.push_back(hold_q.pop_front());
      else begin
        exp_q.push_back(IDLE_B);
        exp_under++;
      end
    end
    rx_got.delete();
    u0 = under_cnt;
    if (wr_plan[0]) write_byte(fr_pd[0]);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (5) @(negedge clk);
    check("frame_busy", {31'd0, busy}, 32'd1);
    check("frame_oe", {31'd0, miso_oe}, 32'd1);
    check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
    for (int b = 0; b < nb; b++) begin
      xfer_byte(fr_mo[b], half, wr_plan[b+1], fr_pd[b+1], got);
      check("miso_byte", {24'd0, got}, {24'd0, exp_q[b]});
    end
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rx_count", rx_got.size(), nb);
    for (int b = 0; b < nb; b++)
      if (b < rx_got.size()) check("rx_byte", {24'd0, rx_got[b]}, {24'd0, fr_mo[b]});
    check("underruns", under_cnt - u0, exp_under);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_oe", {31'd0, miso_oe}, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int u0;
    int exp_under;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values();
    repeat (6) @(negedge clk);

    // Basic exchange
    clear_plan();
    fr_prov[0] = 1'b1; fr_pd[0] = 8'hA5; fr_mo[0] = 8'h3C;
    run_frame(1, 4);

    // Back-to-back bytes, third load underruns
    clear_plan();
    fr_prov[0] = 1'b1; fr_pd[0] = 8'h11;
    fr_prov[1] = 1'b1; fr_pd[1] = 8'h22;
    fr_mo[0] = 8'hF0; fr_mo[1] = 8'h0F; fr_mo[2] = 8'h81;
    run_frame(3, 5);

    // Abort after five rising edges
    rx_got.delete();
    u0 = under_cnt;
    exp_under = (hold_q.size() == 0) ? 1 : 0;
    if (hold_q.size() != 0) void'(hold_q.pop_front());
    @(negedge clk);
    ss_n = 1'b0;
    repeat (5) @(negedge clk);
    clock_bits(5, 4);
    repeat (5) @(negedge clk);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_rx_count", rx_got.size(), 0);
    check("abort_oe", {31'd0, miso_oe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_miso", {31'd0, miso}, 32'd0);
    check("abort_underruns", under_cnt - u0, exp_under);
    clear_plan();
    run_frame(1, 4);

    // Reset in the middle of a frame
    @(negedge clk);
    ss_n = 1'b0;
    repeat (5) @(negedge clk);
    clock_bits(3, 4);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_q.delete();
    check_reset_values();
    rx_got.delete();
    u0 = under_cnt;
    clock_bits(8, 4);
    repeat (4) @(negedge clk);
    check("rst_frame_rx_count", rx_got.size(), 0);
    check("rst_frame_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_frame_underruns", under_cnt - u0, 0);
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
    clear_plan();
    fr_prov[0] = 1'b1;
    run_frame(1, 4);

    // Deselected clocking
    rx_got.delete();
    u0 = under_cnt;
    clock_bits(8, 4);
    repeat (4) @(negedge clk);
    check("desel_rx_count", rx_got.size(), 0);
    check("desel_busy", {31'd0, busy}, 32'd0);
    check("desel_oe", {31'd0, miso_oe}, 32'd0);
    check("desel_underruns", under_cnt - u0, 0);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      int nb;
      clear_plan();
      nb = $urandom_range(1, 3);
      for (int k = 0; k <= nb; k++) fr_prov[k] = 1'($urandom_range(0, 1));
      run_frame(nb, $urandom_range(4, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
